// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with LI immediate pairing and redirect flush.
// Optional halt-stop on the zero word is enabled by defining FETCHQ_HALT_STOP_EN.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_inst,
  output logic [15:0] out_imm,
  output logic [15:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);

  logic [15:0]   r_word   [DEPTH];
  logic [15:0]   r_pc     [DEPTH];
  logic          r_is_imm [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_fetch_pc;
  logic          r_imm_next;
  logic          r_fetching;

  logic [PW-1:0] w_next_ptr;
  logic          w_head_li;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_pop_n;
  logic [PW-1:0] w_pop_step;

  assign mem_addr   = r_fetch_pc;
  assign w_next_ptr = r_rd_ptr + PW'(1);
  // A queued immediate is data, so it can never be mistaken for an LI opcode.
  assign w_head_li  = (r_word[r_rd_ptr][15:12] == 4'hA) && !r_is_imm[r_rd_ptr];
  assign w_valid    = w_head_li ? (r_count >= C_TWO) : (r_count >= C_ONE);
  assign w_push     = !redirect && r_fetching && (r_count < C_DEPTH);
  assign w_pop      = !redirect && w_valid && out_ready;
  assign w_pop_n    = w_pop ? (w_head_li ? C_TWO : C_ONE) : '0;
  assign w_pop_step = w_head_li ? PW'(2) : PW'(1);

  always_comb begin
    out_valid = w_valid;
    out_inst  = 16'h0000;
    out_imm   = 16'h0000;
    out_pc    = 16'h0000;
    if (w_valid) begin
      out_inst = r_word[r_rd_ptr];
      out_pc   = r_pc[r_rd_ptr];
      if (w_head_li) begin
        out_imm = r_word[w_next_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= 16'h0000;
      r_imm_next <= 1'b0;
      r_fetching <= 1'b1;
    end else if (redirect) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc;
      r_imm_next <= 1'b0;
      r_fetching <= 1'b1;
    end else begin
      if (w_push) begin
        r_word[r_wr_ptr]   <= mem_rdata;
        r_pc[r_wr_ptr]     <= r_fetch_pc;
        r_is_imm[r_wr_ptr] <= r_imm_next;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
        r_fetch_pc         <= r_fetch_pc + 16'h0001;
        r_imm_next         <= !r_imm_next && (mem_rdata[15:12] == 4'hA);
`ifdef FETCHQ_HALT_STOP_EN
        if ((mem_rdata == 16'h0000) && !r_imm_next) begin
          r_fetching <= 1'b0;
        end
`endif
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + w_pop_step;
      end
      r_count <= r_count + (w_push ? C_ONE : '0) - w_pop_n;
    end
  end

endmodule
